game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer. It owns `game_state` and `is_winner`, which feed the game-over overlay and the sprite/HUD renderers. It runs the title → play → game-over → title cycle, enforces a round timer and a minimum game-over display time, and latches both players' final BCD scores at end of round. It also decides the winner and pulses the score-clear line to the score counters at the start of each round.

## Interface
- `ROUND_FRAMES`, 3600, round length in frames (60 s at 60 Hz); max 65535.
- `OVER_HOLD_FRAMES`, 120, minimum frames the game-over screen is shown before restart is accepted; max 255.

- `Clk` in 1: system clock, single domain.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-`Clk` pulse per video frame (vsync-derived).
- `start_key` in 1: start/restart key level, already synchronous to `Clk`.
- `p1_dead`, `p2_dead` in 1 each: player-out levels from the player logic.
- `p1_score` in 16: live P1 score, 4 BCD digits, digit 3 in [15:12].
- `p2_score` in 16: live P2 score, same layout as `p1_score`.
- `game_state` out 2: 00 title, 01 play, 10 game over; 11 never driven.
- `is_winner` out 2: 0 tie, 1 P1, 2 P2; 3 never driven.
- `final_p1` out 16: P1 score latched at end of round, BCD.
- `final_p2` out 16: P2 score latched at end of round, BCD.
- `score_clear` out 1: one-cycle pulse that resets the score counters.
- `frames_left` out 16: remaining round frames.

## Operation
- States and their `game_state` encoding:
  - TITLE: 00
  - PLAY: 01
  - LATCH: 01
  - OVER: 10
- `start_rise` = `start_key` & ~`start_q`. `start_q` is a register sampling `start_key` every cycle.
- TITLE → PLAY on `start_rise`:
  - `score_clear`=1 for exactly the next cycle.
  - `frames_left` is loaded with `ROUND_FRAMES`.
- PLAY: on each `frame_tick`, `frames_left` decrements, saturating at 0.
- PLAY → LATCH when (`p1_dead` & `p2_dead`) or (`frames_left`==0).
- LATCH, one cycle:
  - `final_p1` ← `p1_score`, `final_p2` ← `p2_score`.
  - `is_winner` ← 1 if `p1_score` > `p2_score`, 2 if less, 0 if equal. The compare is a plain 16-bit unsigned compare, which is valid because the inputs are BCD.
  - The hold counter is loaded with `OVER_HOLD_FRAMES`.
  - Next state is always OVER.
- OVER: on each `frame_tick`, the hold counter decrements, saturating at 0.
- OVER → TITLE on `start_rise` only when the hold counter is 0. A `start_rise` while the counter is nonzero is discarded, not queued.
- On entering TITLE, `is_winner` and the `final_*` outputs keep their values. They are overwritten only by the next LATCH.
- Boundary conditions:
  - Both players die and the timer expires in the same cycle: exactly one LATCH.
  - `start_key` held high continuously produces no repeated transitions. A release and re-press is required.
  - `frame_tick` coincident with the PLAY → LATCH transition: the decrement still applies, with no other effect.
  - `OVER_HOLD_FRAMES`=0: restart is accepted on the first `start_rise` in OVER.

## Timing
- Reset values:
  - state TITLE, `game_state`=00, `is_winner`=0.
  - `final_p1` = `final_p2` = 0, `score_clear`=0.
  - `frames_left`=`ROUND_FRAMES`, hold counter 0.
  - `start_q`=1, so a key held through reset does not start a game.
- All outputs are registered. `game_state` changes on the same edge as the state register.
- Start latency: the edge that samples `start_key`=1 with `start_q`=0 moves the state to PLAY. `score_clear` is high during the following cycle only.
- End-of-round latency: the condition is sampled at edge N. State is LATCH after N and OVER after N+1. `final_*` and `is_winner` are valid from edge N+1, and are valid no later than `game_state`=10.
- `Reset` asserted in any state returns to reset values immediately (asynchronous). The first state transition is possible on the first edge after deassertion.

## Configuration
- `GAME_TIMER_EN` defined: round timer active as described above.
- `GAME_TIMER_EN` undefined:
  - The timer logic is removed and `frames_left` is tied to 0.
  - PLAY → LATCH occurs only on `p1_dead` & `p2_dead`.

## Test plan
- Reset with `start_key`=1 held, then 10 cycles → `game_state` stays 00 and `score_clear` stays 0. Release then press → `game_state`=01 and a single `score_clear` pulse.
- `p1_score`=16'h0120, `p2_score`=16'h0095, both dead → `final_p1`=0120, `final_p2`=0095, `is_winner`=1, `game_state`=10 two edges later.
- Equal scores 16'h0300 ending via timer (`ROUND_FRAMES`=5, 5 ticks) → `is_winner`=0 and `frames_left`=0.
- In OVER, `start_rise` after 50 of 120 ticks → remains 10. After 120 ticks, `start_rise` → 00.
- Both players dead and `frames_left` reaching 0 on the same cycle → exactly one LATCH cycle. `Reset` pulsed in OVER → all outputs return to reset values.
- `GAME_TIMER_EN` undefined, 5000 ticks with no deaths → remains 01.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer.
//
// Runs the title -> play -> game-over -> title cycle. It enforces a round
// timer and a minimum game-over display time. At end of round it latches
// both players' BCD scores and decides the winner. It pulses score_clear
// once at the start of each round.
//
// Optional feature macro: GAME_TIMER_EN.
//   Defined   - the round timer counts frames; the round also ends when it
//               reaches 0.
//   Undefined - the timer is removed, frames_left reads 0, and a round ends
//               only when both players are dead.
//
// Ports:
//   Clk, Reset              system clock; asynchronous active-high reset
//   frame_tick              one-cycle pulse per video frame
//   start_key               start/restart key level (synchronous)
//   p1_dead, p2_dead        player-out levels
//   p1_score, p2_score      live 4-digit BCD scores
//   game_state              00 title, 01 play, 10 game over
//   is_winner               0 tie, 1 P1, 2 P2
//   final_p1, final_p2      scores latched at end of round
//   score_clear             one-cycle pulse at round start
//   frames_left             remaining round frames

module game_flow_ctrl #(
    parameter int unsigned ROUND_FRAMES     = 3600,
    parameter int unsigned OVER_HOLD_FRAMES = 120
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        start_key,
    input  logic        p1_dead,
    input  logic        p2_dead,
    input  logic [15:0] p1_score,
    input  logic [15:0] p2_score,
    output logic [1:0]  game_state,
    output logic [1:0]  is_winner,
    output logic [15:0] final_p1,
    output logic [15:0] final_p2,
    output logic        score_clear,
    output logic [15:0] frames_left
);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_PLAY  = 2'd1,
        S_LATCH = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_INIT = OVER_HOLD_FRAMES[7:0];

    state_t     state;
    logic       start_q;
    logic [7:0] hold_cnt;
    logic       start_rise;
    logic       both_dead;
    logic       time_up;

    assign start_rise = start_key & ~start_q;
    assign both_dead  = p1_dead & p2_dead;

`ifdef GAME_TIMER_EN
    localparam logic [15:0] ROUND_INIT = ROUND_FRAMES[15:0];
    logic [15:0] frames_q;
    assign frames_left = frames_q;
    assign time_up     = (frames_q == 16'd0);
`else
    // Without the timer the round length has no effect. Folding it into the
    // zero constant keeps the parameter referenced.
    assign frames_left = ROUND_FRAMES[15:0] & 16'h0000;
    assign time_up     = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_TITLE;
            game_state  <= 2'b00;
            is_winner   <= 2'd0;
            final_p1    <= 16'h0000;
            final_p2    <= 16'h0000;
            score_clear <= 1'b0;
            hold_cnt    <= 8'd0;
            // Reset to 1 so that a key held through reset does not count as a press.
            start_q     <= 1'b1;
`ifdef GAME_TIMER_EN
            frames_q    <= ROUND_INIT;
`endif
        end else begin
            start_q     <= start_key;
            score_clear <= 1'b0;
            case (state)
                S_TITLE: begin
                    if (start_rise) begin
                        state       <= S_PLAY;
                        game_state  <= 2'b01;
                        score_clear <= 1'b1;
`ifdef GAME_TIMER_EN
                        frames_q    <= ROUND_INIT;
`endif
                    end
                end
                S_PLAY: begin
`ifdef GAME_TIMER_EN
                    // The tick applies even on the cycle the round ends.
                    if (frame_tick && (frames_q != 16'd0))
                        frames_q <= frames_q - 16'd1;
`endif
                    if (both_dead || time_up)
                        state <= S_LATCH;
                end
                S_LATCH: begin
                    final_p1   <= p1_score;
                    final_p2   <= p2_score;
                    // In BCD, digit order matches bit significance, so a binary compare ranks the scores correctly.
                    is_winner  <= (p1_score > p2_score) ? 2'd1 :
                                  (p1_score < p2_score) ? 2'd2 : 2'd0;
                    hold_cnt   <= HOLD_INIT;
                    state      <= S_OVER;
                    game_state <= 2'b10;
                end
                S_OVER: begin
                    if (frame_tick && (hold_cnt != 8'd0))
                        hold_cnt <= hold_cnt - 8'd1;
                    // A press that arrives before the hold expires is dropped.
                    if (start_rise && (hold_cnt == 8'd0)) begin
                        state      <= S_TITLE;
                        game_state <= 2'b00;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

    localparam int RF = 5;
    localparam int HF = 120;
`ifdef GAME_TIMER_EN
    localparam logic [31:0] EXP_RF = 32'd5;
`else
    localparam logic [31:0] EXP_RF = 32'd0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        start_key;
    logic        p1_dead;
    logic        p2_dead;
    logic [15:0] p1_score;
    logic [15:0] p2_score;
    logic [1:0]  game_state;
    logic [1:0]  is_winner;
    logic [15:0] final_p1;
    logic [15:0] final_p2;
    logic        score_clear;
    logic [15:0] frames_left;

    typedef struct packed {
        logic [15:0] p1;
        logic [15:0] p2;
        logic [1:0]  w;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    game_flow_ctrl #(.ROUND_FRAMES(RF), .OVER_HOLD_FRAMES(HF)) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_key(start_key),
        .p1_dead(p1_dead), .p2_dead(p2_dead), .p1_score(p1_score), .p2_score(p2_score),
        .game_state(game_state), .is_winner(is_winner), .final_p1(final_p1),
        .final_p2(final_p2), .score_clear(score_clear), .frames_left(frames_left)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic press_start();
        start_key = 1'b1;
        @(negedge Clk);
        start_key = 1'b0;
        @(negedge Clk);
    endtask

    task automatic start_game();
        start_key = 1'b0;
        @(negedge Clk);
        start_key = 1'b1;
        @(negedge Clk);
        check("start_state", {30'd0, game_state}, 32'd1);
        check("start_clear", {31'd0, score_clear}, 32'd1);
        check("start_frames", {16'd0, frames_left}, EXP_RF);
        @(negedge Clk);
        check("clear_once", {31'd0, score_clear}, 32'd0);
        start_key = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic [1:0] w);
        exp_t e;
        e.p1 = a; e.p2 = b; e.w = w;
        sb.push_back(e);
        p1_score = a;
        p2_score = b;
    endtask

    // Caller has just set the end-of-round condition (or it is already pending).
    task automatic expect_latch();
        exp_t e;
        @(negedge Clk);
        frame_tick = 1'b0;
        check("latch_state", {30'd0, game_state}, 32'd1);
        @(negedge Clk);
        check("over_state", {30'd0, game_state}, 32'd2);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("final_p1", {16'd0, final_p1}, {16'd0, e.p1});
            check("final_p2", {16'd0, final_p2}, {16'd0, e.p2});
            check("winner", {30'd0, is_winner}, {30'd0, e.w});
        end
    endtask

    task automatic exit_over();
        p1_dead = 1'b0;
        p2_dead = 1'b0;
        do_ticks(HF);
        press_start();
        check("over_exit", {30'd0, game_state}, 32'd0);
    endtask

    task automatic reset_pulse_check();
        #2 Reset = 1'b1;
        #1;
        check("rst_state", {30'd0, game_state}, 32'd0);
        check("rst_winner", {30'd0, is_winner}, 32'd0);
        check("rst_final_p1", {16'd0, final_p1}, 32'd0);
        check("rst_final_p2", {16'd0, final_p2}, 32'd0);
        check("rst_clear", {31'd0, score_clear}, 32'd0);
        check("rst_frames", {16'd0, frames_left}, EXP_RF);
        @(negedge Clk);
        Reset = 1'b0;
        p1_dead = 1'b0;
        p2_dead = 1'b0;
        @(negedge Clk);
        check("post_rst_state", {30'd0, game_state}, 32'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; start_key = 1'b1;
        p1_dead = 1'b0; p2_dead = 1'b0; p1_score = 16'h0; p2_score = 16'h0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("reset_state", {30'd0, game_state}, 32'd0);
        check("reset_winner", {30'd0, is_winner}, 32'd0);
        check("reset_final_p1", {16'd0, final_p1}, 32'd0);
        check("reset_frames", {16'd0, frames_left}, EXP_RF);

        // Key held through reset must not start a game.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("held_state", {30'd0, game_state}, 32'd0);
            check("held_clear", {31'd0, score_clear}, 32'd0);
        end

        // Both dead, P1 ahead.
        start_game();
        push_exp(16'h0120, 16'h0095, 2'd1);
        p1_dead = 1'b1; p2_dead = 1'b1;
        expect_latch();
        p1_dead = 1'b0; p2_dead = 1'b0;

        // Restart is refused until the hold reaches zero.
        do_ticks(50);
        press_start();
        check("hold_50", {30'd0, game_state}, 32'd2);
        do_ticks(69);
        press_start();
        check("hold_119", {30'd0, game_state}, 32'd2);
        do_ticks(1);
        press_start();
        check("hold_done", {30'd0, game_state}, 32'd0);
        check("keep_winner", {30'd0, is_winner}, 32'd1);
        check("keep_final_p1", {16'd0, final_p1}, 32'h0120);

`ifdef GAME_TIMER_EN
        // Equal scores, round ends on the timer.
        start_game();
        push_exp(16'h0300, 16'h0300, 2'd0);
        for (int k = 1; k <= RF; k++) begin
            frame_tick = 1'b1;
            @(negedge Clk);
            frame_tick = 1'b0;
            check("frames_dec", {16'd0, frames_left}, RF - k);
            check("play_state", {30'd0, game_state}, 32'd1);
        end
        expect_latch();
        check("timer_frames0", {16'd0, frames_left}, 32'd0);
        exit_over();

        // frame_tick on the same cycle as the deaths still decrements.
        start_game();
        push_exp(16'h0042, 16'h1234, 2'd2);
        p1_dead = 1'b1; p2_dead = 1'b1; frame_tick = 1'b1;
        expect_latch();
        check("coinc_tick", {16'd0, frames_left}, 32'd4);
        exit_over();

        // Deaths and timer expiry on the same cycle: one latch only.
        start_game();
        push_exp(16'h0500, 16'h0400, 2'd1);
        do_ticks(RF - 1);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        check("both_pre_frames", {16'd0, frames_left}, 32'd0);
        check("both_pre_state", {30'd0, game_state}, 32'd1);
        p1_dead = 1'b1; p2_dead = 1'b1;
        expect_latch();
        @(negedge Clk);
        check("both_stay_over", {30'd0, game_state}, 32'd2);
        check("both_sb_empty", sb.size(), 32'd0);
        reset_pulse_check();
`else
        // Without the timer, the round never ends on its own.
        start_game();
        do_ticks(5000);
        check("no_timer_state", {30'd0, game_state}, 32'd1);
        check("no_timer_frames", {16'd0, frames_left}, 32'd0);
        push_exp(16'h0042, 16'h1234, 2'd2);
        p1_dead = 1'b1; p2_dead = 1'b1;
        expect_latch();
        reset_pulse_check();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
